// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: one-cycle tick every DIV clocks, restartable from zero.
module baud_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// 8N1 UART transmitter shared by two requesters under round-robin arbitration.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned BR   = 9600,
    parameter int unsigned CLKF = 12000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 grant
);

    localparam int unsigned BR_SAFE = (BR == 0) ? 1 : BR;
    localparam int unsigned DIV     = CLKF / BR_SAFE;
    localparam int unsigned BCW     = $clog2(DATA_BITS);

    if (BR == 0 || CLKF == 0 || (CLKF % BR_SAFE) != 0 || DIV < 2) begin : g_param_check
        $fatal(1, "uart_tx_scheduler: BR/CLKF must give an integer divider of at least 2");
    end

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 grant_q, grant_d;
    logic                 prio_q, prio_d;
    logic                 sel;
    logic                 accept;
    logic                 tick;

    // prio_q names the requester that wins a tie; it points away from the last one served
    assign sel        = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign req0_ready = !reset && (state_q == ST_IDLE) && req0_valid && !sel;
    assign req1_ready = !reset && (state_q == ST_IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign grant = grant_q;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        grant_d   = grant_q;
        prio_d    = prio_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = ST_START;
                    shreg_d = sel ? req1_data : req0_data;
                    tx_d    = 1'b0;
                    grant_d = sel;
                    prio_d  = ~sel;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: scenario tasks checked against a queue-based line model.
module tb_uart_tx_scheduler;

    localparam int unsigned BR   = 1;
    localparam int unsigned CLKF = 4;
    localparam int unsigned DIV  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, tx, busy, grant;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_scheduler #(
        .BR  (BR),
        .CLKF(CLKF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .tx        (tx),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    // Line model: each accepted byte appends its whole 10*DIV-cycle waveform to a queue.
    bit         line_q[$];
    bit         m_prio = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_tx = 1'b1;
    bit         m_grant = 1'b0;
    logic [7:0] m_byte;
    logic [9:0] m_frame;

    wire m_sel  = (req0_valid && req1_valid) ? m_prio : req1_valid;
    wire exp_r0 = !reset && !m_busy && req0_valid && !m_sel;
    wire exp_r1 = !reset && !m_busy && req1_valid && m_sel;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q.delete();
            m_prio  = 1'b0;
            m_busy  = 1'b0;
            m_tx    = 1'b1;
            m_grant = 1'b0;
        end else begin
            if (exp_r0 || exp_r1) begin
                m_byte  = exp_r1 ? req1_data : req0_data;
                m_grant = exp_r1;
                m_prio  = !exp_r1;
                m_frame = {1'b1, m_byte, 1'b0};
                for (int b = 0; b < 10; b++)
                    for (int k = 0; k < int'(DIV); k++)
                        line_q.push_back(m_frame[b]);
            end
            m_busy = (line_q.size() != 0);
            m_tx   = m_busy ? line_q.pop_front() : 1'b1;
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tx, busy, grant} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_outputs: tx/busy/grant got %b expected 100", {tx, busy, grant});
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ready: ready got %b expected 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({tx, busy, grant, req0_ready, req1_ready} !== 5'b10000) begin
                n_errors++;
                $display("FAIL idle_after_reset: tx/busy/grant/r0/r1 got %b expected 10000",
                         {tx, busy, grant, req0_ready, req1_ready});
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] frame;
        int         busy_cycles = 0;
        bit         exp_tx;
        pulse_reset();
        frame      = {1'b1, 8'hA5, 1'b0};
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL single_ready: ready got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        for (int k = 0; k < 44; k++) begin
            exp_tx = (k < 40) ? frame[k / 4] : 1'b1;
            n_checks++;
            if (tx !== exp_tx || busy !== (k < 40)) begin
                n_errors++;
                $display("FAIL single_wave[%0d]: tx=%b busy=%b expected tx=%b busy=%b",
                         k, tx, busy, exp_tx, (k < 40));
            end
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy_cycles != 40 || grant !== 1'b0) begin
            n_errors++;
            $display("FAIL single_busy_len: busy=%0d grant=%b expected 40 and 0", busy_cycles, grant);
        end
    endtask

    task automatic test_alternate();
        bit who[$];
        pulse_reset();
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 90; c++) begin
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {exp_r0, exp_r1} || (req0_ready && req1_ready)) begin
                n_errors++;
                $display("FAIL alt_ready[%0d]: ready got %b expected %b", c,
                         {req0_ready, req1_ready}, {exp_r0, exp_r1});
            end
            if (req0_ready || req1_ready) who.push_back(req1_ready);
            @(posedge clk); #1;
            n_checks++;
            if ({tx, busy, grant} !== {m_tx, m_busy, m_grant}) begin
                n_errors++;
                $display("FAIL alt_line[%0d]: tx/busy/grant got %b expected %b", c,
                         {tx, busy, grant}, {m_tx, m_busy, m_grant});
            end
        end
        n_checks++;
        if (who.size() < 3 || who[0] != 1'b0 || who[1] != 1'b1 || who[2] != 1'b0) begin
            n_errors++;
            $display("FAIL alt_order: %0d grants seen, first three %0d%0d%0d expected 010",
                     who.size(), (who.size() > 0) ? who[0] : 1'b1,
                     (who.size() > 1) ? who[1] : 1'b0, (who.size() > 2) ? who[2] : 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc_at[$];
        int idle_cnt = 0;
        bit idle_tx_ok = 1'b1;
        pulse_reset();
        req1_data  = 8'h3C;
        req1_valid = 1'b1;
        for (int c = 0; c < 90; c++) begin
            #1;
            if (req1_ready) acc_at.push_back(c);
            @(posedge clk); #1;
            n_checks++;
            if ({tx, busy, grant} !== {m_tx, m_busy, m_grant}) begin
                n_errors++;
                $display("FAIL b2b_line[%0d]: tx/busy/grant got %b expected %b", c,
                         {tx, busy, grant}, {m_tx, m_busy, m_grant});
            end
            if (acc_at.size() == 1 && busy === 1'b0) begin
                idle_cnt++;
                if (tx !== 1'b1) idle_tx_ok = 1'b0;
            end
        end
        n_checks++;
        if (acc_at.size() < 2 || (acc_at[1] - acc_at[0]) != 41) begin
            n_errors++;
            $display("FAIL b2b_period: %0d accepts, spacing %0d expected 41", acc_at.size(),
                     (acc_at.size() >= 2) ? acc_at[1] - acc_at[0] : -1);
        end
        n_checks++;
        if (idle_cnt != 1 || !idle_tx_ok) begin
            n_errors++;
            $display("FAIL b2b_idle: idle cycles %0d (tx high %b) expected 1 (1)", idle_cnt, idle_tx_ok);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        pulse_reset();
        req1_data  = 8'($urandom);
        req1_valid = 1'b1;
        for (int c = 0; c < 4 && !got; c++) begin
            #1;
            got = req1_ready;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL mid_accept: req1 not accepted within 4 cycles, expected acceptance");
        end
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tx, busy, grant, req0_ready, req1_ready} !== 5'b10000) begin
            n_errors++;
            $display("FAIL mid_reset_now: tx/busy/grant/r0/r1 got %b expected 10000",
                     {tx, busy, grant, req0_ready, req1_ready});
        end
        req0_data  = 8'($urandom);
        req0_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL mid_next_sel: ready got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({tx, busy, grant} !== 3'b010) begin
            n_errors++;
            $display("FAIL mid_next_frame: tx/busy/grant got %b expected 010", {tx, busy, grant});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_random();
        bit acc0 = 1'b0;
        bit acc1 = 1'b0;
        pulse_reset();
        for (int c = 0; c < 800; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_data  = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_data  = 8'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                req1_valid = 1'b0;
            end
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== {exp_r0, exp_r1} || (req0_ready && req1_ready)) begin
                n_errors++;
                $display("FAIL rand_ready[%0d]: ready got %b expected %b", c,
                         {req0_ready, req1_ready}, {exp_r0, exp_r1});
            end
            acc0 = req0_ready;
            acc1 = req1_ready;
            @(posedge clk); #1;
            n_checks++;
            if ({tx, busy, grant} !== {m_tx, m_busy, m_grant}) begin
                n_errors++;
                $display("FAIL rand_line[%0d]: tx/busy/grant got %b expected %b", c,
                         {tx, busy, grant}, {m_tx, m_busy, m_grant});
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
